// File: rtl/spy_protocol_pkg.sv
// spy_protocol_pkg: shared state encoding and event-list codes for the spy readout path.
package spy_protocol_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FREEZE_WAIT,
        S_META_RD,
        S_META_CHK,
        S_DATA_REQ,
        S_DATA_CAP,
        S_DATA_OUT,
        S_RELEASE
    } state_t;

    // Value of the event-list MSB that marks a start-of-event entry (1 = sentinel).
    localparam logic START_EVENT = 1'b0;

endpackage

// File: rtl/spy_event_reader.sv
// spy_event_reader: freezes the spy buffer, finds the newest SOE and streams that event's words.
module spy_event_reader
    import spy_protocol_pkg::*;
#(
    parameter int DATAWIDTH     = 64,
    parameter int MEMWIDTH      = 6,
    parameter int METAWIDTH     = 4,
    parameter int FREEZE_SETTLE = 2
) (
    input  logic                 clock,
    input  logic                 resetbar,
    input  logic                 start,
    output logic                 freeze_req,
    input  logic [METAWIDTH-1:0] meta_write_addr,
    input  logic [MEMWIDTH-1:0]  mem_wptr,
    output logic                 meta_read_enable,
    output logic [METAWIDTH-1:0] meta_read_addr,
    input  logic [MEMWIDTH:0]    meta_read_data,
    output logic                 read_enable,
    output logic [MEMWIDTH-1:0]  read_addr,
    input  logic [DATAWIDTH:0]   data_in,
    output logic [DATAWIDTH:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [MEMWIDTH:0]    event_len,
    output logic                 busy,
    output logic                 error
);

    localparam int SENTINEL_BIT = MEMWIDTH;
    localparam int CW = (FREEZE_SETTLE > 1) ? $clog2(FREEZE_SETTLE) : 1;

    state_t                 state, state_nx;
    logic [CW-1:0]          settle;
    logic [MEMWIDTH-1:0]    end_ptr, rd_ptr, len_raw;
    logic [METAWIDTH-1:0]   mptr;
    logic [METAWIDTH:0]     scanned;
    logic [1:0]             sentinels;
    logic [MEMWIDTH:0]      remaining;
    logic                   settle_done, is_sentinel, meta_fail, last_word;

    assign settle_done = settle == CW'(FREEZE_SETTLE - 1);
    assign is_sentinel = meta_read_data[SENTINEL_BIT] != START_EVENT;
    assign len_raw     = end_ptr - meta_read_data[MEMWIDTH-1:0];
    assign last_word   = remaining == (MEMWIDTH+1)'(1);
    // A second sentinel means the SOE was overwritten; a full lap without SOE is also fatal.
    assign meta_fail   = is_sentinel
                         ? (sentinels == 2'd1 || scanned == (METAWIDTH+1)'((1 << METAWIDTH) - 1))
                         : (len_raw == '0);

    assign freeze_req       = state != S_IDLE && state != S_RELEASE;
    assign busy             = freeze_req;
    assign meta_read_enable = state == S_META_RD;
    assign meta_read_addr   = mptr;
    assign read_enable      = state == S_DATA_REQ;
    assign read_addr        = rd_ptr;
    assign out_valid        = state == S_DATA_OUT;

    always_ff @(posedge clock) begin
        if (!resetbar) state <= S_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:        state_nx = start ? S_FREEZE_WAIT : S_IDLE;
            S_FREEZE_WAIT: state_nx = settle_done ? S_META_RD : S_FREEZE_WAIT;
            S_META_RD:     state_nx = S_META_CHK;
            S_META_CHK:    state_nx = meta_fail ? S_RELEASE : is_sentinel ? S_META_RD : S_DATA_REQ;
            S_DATA_REQ:    state_nx = S_DATA_CAP;
            S_DATA_CAP:    state_nx = S_DATA_OUT;
            S_DATA_OUT:    state_nx = !out_ready ? S_DATA_OUT : last_word ? S_RELEASE : S_DATA_REQ;
            S_RELEASE:     state_nx = S_IDLE;
            default:       state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetbar) begin
            settle    <= '0;
            end_ptr   <= '0;
            rd_ptr    <= '0;
            mptr      <= '0;
            scanned   <= '0;
            sentinels <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            event_len <= '0;
            error     <= 1'b0;
        end else begin
            error <= state == S_META_CHK && meta_fail;
            if (state == S_FREEZE_WAIT) begin
                settle <= settle_done ? '0 : settle + 1'b1;
                if (settle_done) begin
                    end_ptr   <= mem_wptr;
                    mptr      <= meta_write_addr - METAWIDTH'(1);
                    scanned   <= '0;
                    sentinels <= '0;
                end
            end
            if (state == S_META_CHK) begin
                scanned <= scanned + 1'b1;
                if (is_sentinel) begin
                    sentinels <= sentinels + 1'b1;
                    mptr      <= mptr - METAWIDTH'(1);
                end else begin
                    event_len <= {1'b0, len_raw};
                    remaining <= {1'b0, len_raw};
                    rd_ptr    <= meta_read_data[MEMWIDTH-1:0];
                end
            end
            if (state == S_DATA_CAP) begin
                out_data <= data_in;
                out_last <= last_word;
            end
            if (state == S_DATA_OUT && out_ready) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

endmodule
